matvec_mul_ctrl: RTL and testbench
==================================

MATVEC_MUL_CTRL -- requirements
Module: matvec_mul_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have ports: start  in  1  one-cycle request to begin a matrix-vector product; rank  in  3  module rank L (2, 3 or 4), sampled on accepted start.
REQ-003 SHALL have multiplier-side ports: mul_rst  out  1  restarts the multiplier for one column; mul_acc_clear  out  1  clears the multiplier accumulator; mul_read  out  1  rotates the accumulator for readout; mul_done  in  1  multiplier product complete (level).
REQ-004 SHALL have address ports: a_base  out  10  word base of polynomial A[i][j]; s_base  out  6  word base of secret s[j].
REQ-005 SHALL have result/status ports: res_we  out  1  result write strobe; res_addr  out  8  result word address; busy  out  1  product in progress; done  out  1  one-cycle completion pulse; err  out  1  one-cycle illegal-rank pulse.

Function
REQ-006 SHALL implement states IDLE, CLR, MRST, WAIT, READ, FIN.
REQ-007 IDLE: start with rank in {2,3,4} SHALL latch L, clear row/col to 0 and go to CLR next cycle; start with any other rank SHALL pulse err for one cycle and stay IDLE.
REQ-008 CLR SHALL assert mul_acc_clear for exactly one cycle, then go to MRST.
REQ-009 MRST SHALL assert mul_rst for exactly one cycle, then go to WAIT; a_base and s_base SHALL be stable from MRST until WAIT exits.
REQ-010 a_base SHALL equal (row*L+col)*52; s_base SHALL equal col*16.
REQ-011 WAIT SHALL hold until mul_done=1; then, if col<L-1, col increments and the FSM goes to MRST, with no accumulator clear; otherwise it goes to READ.
REQ-012 READ SHALL last exactly 64 cycles; each cycle SHALL assert mul_read and res_we together, with res_addr = row*64+k, k = 0..63.
REQ-013 After READ, if row<L-1, row increments, col resets to 0 and the FSM goes to CLR; otherwise it goes to FIN.
REQ-014 FIN SHALL pulse done for one cycle, then go to IDLE.
REQ-015 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored.
REQ-016 Total mul_rst pulses per product SHALL be L*L; mul_acc_clear pulses SHALL be L; res_we cycles SHALL be 64*L.
REQ-017 mul_done already high on WAIT entry SHALL be ignored for that cycle; WAIT SHALL sample it no earlier than one cycle after MRST.

Reset
REQ-018 rst SHALL force IDLE, zero row/col/k, and zero every output, including mid-operation; no done pulse SHALL be emitted for an aborted product.
REQ-019 rst and start asserted in the same cycle: rst SHALL win.

Configuration
REQ-020 Macro MATVEC_TRANSPOSE_EN: when defined, input port transpose (1 bit, sampled with start) SHALL exist, and transpose=1 SHALL give a_base=(col*L+row)*52; when undefined, the port SHALL be absent and non-transposed addressing SHALL apply.

Structure
REQ-021 Package matvec_pkg SHALL hold A_WORDS=52, S_WORDS=16, RES_WORDS=64, the state enum, and the legal rank bounds.
REQ-022 Address arithmetic SHALL sit in one sub-module matvec_addr_gen (row, col, k, L, transpose -> a_base, s_base, res_addr).

Verification
REQ-023 rst, then start with rank=3 and mul_done returned 5 cycles after each mul_rst -> 9 mul_rst, 3 mul_acc_clear, 192 res_we with res_addr 0..191, one done pulse, then busy=0.
REQ-024 rank=2 -> a_base sequence 0,52,104,156; s_base sequence 0,16,0,16.
REQ-025 start with rank=5 (and with rank=1) -> err pulse, busy stays 0, no multiplier strobes.
REQ-026 rst asserted during READ at k=20 -> next cycle IDLE, all outputs 0, no done pulse; a new start with rank=4 then completes with 16 mul_rst pulses.
REQ-027 start re-asserted during WAIT -> ignored; the product completes with unchanged counts.
REQ-028 MATVEC_TRANSPOSE_EN defined, rank=3, transpose=1 -> a_base for row 0 is 0,156,312.

Source files
------------

// File: rtl/matvec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matvec_pkg
// Description : Shared constants, FSM state encoding and rank check for the
//               matrix-vector multiply controller.
// Revision    : 1.0 - initial release
// ============================================================================
package matvec_pkg;

  // Word counts of one polynomial in each memory region.
  localparam int A_WORDS   = 52;
  localparam int S_WORDS   = 16;
  localparam int RES_WORDS = 64;

  // Legal module rank range.
  localparam int RANK_MIN = 2;
  localparam int RANK_MAX = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_MRST = 3'd2,
    ST_WAIT = 3'd3,
    ST_READ = 3'd4,
    ST_FIN  = 3'd5
  } state_e;

  function automatic logic rank_legal(input logic [2:0] r);
    return (r >= 3'(RANK_MIN)) && (r <= 3'(RANK_MAX));
  endfunction

endpackage
`default_nettype wire

// File: rtl/matvec_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : matvec_addr_gen
// Description : Combinational address arithmetic for the matvec controller.
//               a_base = (major*L + minor)*A_WORDS, where (major,minor) is
//               (row,col) or (col,row) when transposed.
//               s_base = col*S_WORDS, res_addr = row*RES_WORDS + k.
// Ports       : row_i, col_i     - current matrix indices
//               k_i              - readout word index
//               rank_i           - latched rank L
//               transpose_i      - swap row/col for A addressing
//               a_base_o, s_base_o, res_addr_o - word addresses
// Revision    : 1.0 - initial release
// ============================================================================
module matvec_addr_gen
  import matvec_pkg::*;
(
  input  logic [1:0] row_i,
  input  logic [1:0] col_i,
  input  logic [5:0] k_i,
  input  logic [2:0] rank_i,
  input  logic       transpose_i,
  output logic [9:0] a_base_o,
  output logic [5:0] s_base_o,
  output logic [7:0] res_addr_o
);

  logic [1:0] w_major;
  logic [1:0] w_minor;
  logic [3:0] w_idx;

  always_comb begin
    w_major    = transpose_i ? col_i : row_i;
    w_minor    = transpose_i ? row_i : col_i;
    // Largest index is 3*4+3 = 15, so 4 bits suffice.
    w_idx      = 4'(w_major) * 4'(rank_i) + 4'(w_minor);
    a_base_o   = 10'(w_idx) * 10'(A_WORDS);
    s_base_o   = 6'(col_i) * 6'(S_WORDS);
    res_addr_o = 8'(row_i) * 8'(RES_WORDS) + 8'(k_i);
  end

endmodule
`default_nettype wire

// File: rtl/matvec_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : matvec_mul_ctrl
// Description : Sequences a polynomial multiplier through an LxL
//               matrix-vector product: per row it clears the accumulator,
//               runs L column products, then reads out 64 result words.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               start, rank       - request and rank L (2..4)
//               transpose         - A-transposed addressing (optional)
//               mul_rst, mul_acc_clear, mul_read, mul_done - multiplier side
//               a_base, s_base    - operand word bases
//               res_we, res_addr  - result write port
//               busy, done, err   - status
// Config      : MATVEC_TRANSPOSE_EN adds the transpose input.
// Revision    : 1.0 - initial release
// ============================================================================
module matvec_mul_ctrl
  import matvec_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] rank,
`ifdef MATVEC_TRANSPOSE_EN
  input  logic       transpose,
`endif
  output logic       mul_rst,
  output logic       mul_acc_clear,
  output logic       mul_read,
  input  logic       mul_done,
  output logic [9:0] a_base,
  output logic [5:0] s_base,
  output logic       res_we,
  output logic [7:0] res_addr,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_e     state_q, state_d;
  logic [1:0] row_q, row_d;
  logic [1:0] col_q, col_d;
  logic [5:0] k_q, k_d;
  logic [2:0] l_q, l_d;
  logic       tr_q, tr_d;
  logic       err_q, err_d;
  // High from the second WAIT cycle on, so a mul_done left over from the
  // previous column is never taken on WAIT entry.
  logic       wait_arm_q;
  logic       w_tr_in;

`ifdef MATVEC_TRANSPOSE_EN
  assign w_tr_in = transpose;
`else
  assign w_tr_in = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      row_q      <= 2'd0;
      col_q      <= 2'd0;
      k_q        <= 6'd0;
      l_q        <= 3'd0;
      tr_q       <= 1'b0;
      err_q      <= 1'b0;
      wait_arm_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      k_q        <= k_d;
      l_q        <= l_d;
      tr_q       <= tr_d;
      err_q      <= err_d;
      wait_arm_q <= (state_q == ST_WAIT);
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    k_d     = k_q;
    l_d     = l_q;
    tr_d    = tr_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (rank_legal(rank)) begin
            l_d     = rank;
            tr_d    = w_tr_in;
            row_d   = 2'd0;
            col_d   = 2'd0;
            k_d     = 6'd0;
            state_d = ST_CLR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_CLR:  state_d = ST_MRST;
      ST_MRST: state_d = ST_WAIT;
      ST_WAIT: begin
        if (wait_arm_q && mul_done) begin
          if ({1'b0, col_q} < (l_q - 3'd1)) begin
            col_d   = col_q + 2'd1;
            state_d = ST_MRST;
          end else begin
            k_d     = 6'd0;
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        k_d = k_q + 6'd1;
        if (k_q == 6'(RES_WORDS - 1)) begin
          k_d = 6'd0;
          if ({1'b0, row_q} < (l_q - 3'd1)) begin
            row_d   = row_q + 2'd1;
            col_d   = 2'd0;
            state_d = ST_CLR;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign mul_acc_clear = (state_q == ST_CLR);
  assign mul_rst       = (state_q == ST_MRST);
  assign mul_read      = (state_q == ST_READ);
  assign res_we        = (state_q == ST_READ);
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_FIN);
  assign err           = err_q;

  matvec_addr_gen u_addr_gen (
    .row_i       (row_q),
    .col_i       (col_q),
    .k_i         (k_q),
    .rank_i      (l_q),
    .transpose_i (tr_q),
    .a_base_o    (a_base),
    .s_base_o    (s_base),
    .res_addr_o  (res_addr)
  );

endmodule
`default_nettype wire

// File: tb/tb_matvec_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_matvec_mul_ctrl
// Description : Directed self-checking bench for matvec_mul_ctrl with a
//               behavioural multiplier that raises mul_done 5 cycles after
//               each mul_rst (or holds it high in forced mode).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_matvec_mul_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, mul_done;
  logic [2:0] rank;
`ifdef MATVEC_TRANSPOSE_EN
  logic       transpose;
`endif
  logic       mul_rst, mul_acc_clear, mul_read, res_we, busy, done, err;
  logic [9:0] a_base;
  logic [5:0] s_base;
  logic [7:0] res_addr;

  always #5 clk = ~clk;

  matvec_mul_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .rank          (rank),
`ifdef MATVEC_TRANSPOSE_EN
    .transpose     (transpose),
`endif
    .mul_rst       (mul_rst),
    .mul_acc_clear (mul_acc_clear),
    .mul_read      (mul_read),
    .mul_done      (mul_done),
    .a_base        (a_base),
    .s_base        (s_base),
    .res_we        (res_we),
    .res_addr      (res_addr),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  int tests = 0;
  int fails = 0;

  // Running totals, written only by the monitor.
  int rst_tot = 0, clr_tot = 0, we_tot = 0, done_tot = 0, err_tot = 0;
  int busy_tot = 0, addr_err = 0, rd_err = 0;
  int rst_ip = 0, we_ip = 0;
  logic [9:0] a_seq [16];
  logic [5:0] s_seq [16];

  // Baselines captured by the main sequence.
  int b_rst, b_clr, b_we, b_done, b_err, b_busy, b_addr, b_rd;

  logic force_high = 1'b0;
  int   dly = 0;

  // Multiplier model.
  initial begin
    mul_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mul_done = 1'b0;
        dly = 0;
      end else if (force_high) begin
        mul_done = 1'b1;
      end else if (mul_rst) begin
        mul_done = 1'b0;
        dly = 5;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) mul_done = 1'b1;
      end
    end
  end

  // Output monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (!busy) begin
        rst_ip = 0;
        we_ip  = 0;
      end
      if (busy) busy_tot++;
      if (mul_rst) begin
        if (rst_ip < 16) begin
          a_seq[rst_ip] = a_base;
          s_seq[rst_ip] = s_base;
        end
        rst_ip++;
        rst_tot++;
      end
      if (mul_acc_clear) clr_tot++;
      if (res_we) begin
        if (res_addr !== we_ip[7:0]) addr_err++;
        we_ip++;
        we_tot++;
      end
      if (mul_read !== res_we) rd_err++;
      if (done) done_tot++;
      if (err) err_tot++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    b_rst = rst_tot;  b_clr = clr_tot;   b_we = we_tot;   b_done = done_tot;
    b_err = err_tot;  b_busy = busy_tot; b_addr = addr_err; b_rd = rd_err;
  endtask

  task automatic do_start(input logic [2:0] r);
    start = 1'b1;
    rank  = r;
`ifdef MATVEC_TRANSPOSE_EN
    transpose = 1'b0;
`endif
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    step(2);
  endtask

  task automatic chk_counts(input string tag, input int n_rst, input int n_clr,
                            input int n_we, input int n_done);
    chk({tag, "_mul_rst"}, rst_tot - b_rst, n_rst);
    chk({tag, "_acc_clr"}, clr_tot - b_clr, n_clr);
    chk({tag, "_res_we"}, we_tot - b_we, n_we);
    chk({tag, "_done"}, done_tot - b_done, n_done);
    chk({tag, "_addr_err"}, addr_err - b_addr, 0);
    chk({tag, "_read_eq_we"}, rd_err - b_rd, 0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, {25'd0, mul_rst, mul_acc_clear, mul_read, res_we, busy, done, err}, 32'd0);
    chk({tag, "_a_base"}, {22'd0, a_base}, 32'd0);
    chk({tag, "_s_base"}, {26'd0, s_base}, 32'd0);
    chk({tag, "_res_addr"}, {24'd0, res_addr}, 32'd0);
  endtask

  initial begin
    int exp_a [4];
    int exp_s [4];
    int n;
    exp_a = '{0, 52, 104, 156};
    exp_s = '{0, 16, 0, 16};
    rst = 1'b1;
    start = 1'b0;
    rank = 3'd0;
`ifdef MATVEC_TRANSPOSE_EN
    transpose = 1'b0;
`endif
    step(3);
    rst = 1'b0;
    step(1);
    chk_quiet("reset");

    // Rank 3 full product.
    snap();
    do_start(3'd3);
    wait_idle("r3");
    chk_counts("r3", 9, 3, 192, 1);
    chk("r3_err", err_tot - b_err, 0);

    // Rank 2 address sequences.
    snap();
    do_start(3'd2);
    wait_idle("r2");
    chk_counts("r2", 4, 2, 128, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("r2_a_base_%0d", i), {22'd0, a_seq[i]}, exp_a[i]);
      chk($sformatf("r2_s_base_%0d", i), {26'd0, s_seq[i]}, exp_s[i]);
    end

    // Illegal ranks.
    snap();
    do_start(3'd5);
    chk("r5_err_pulse", {31'd0, err}, 32'd1);
    chk("r5_busy", {31'd0, busy}, 32'd0);
    step(1);
    chk("r5_err_width", {31'd0, err}, 32'd0);
    do_start(3'd1);
    chk("r1_err_pulse", {31'd0, err}, 32'd1);
    chk("r1_busy", {31'd0, busy}, 32'd0);
    step(3);
    chk("bad_err_cnt", err_tot - b_err, 2);
    chk("bad_busy_cnt", busy_tot - b_busy, 0);
    chk("bad_mul_rst", rst_tot - b_rst, 0);
    chk("bad_acc_clr", clr_tot - b_clr, 0);

    // Reset during READ at k=20, then a rank-4 product.
    snap();
    do_start(3'd3);
    n = 0;
    while (!(res_we && res_addr == 8'd20) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_k20", {24'd0, res_addr}, 32'd20);
    rst = 1'b1;
    step(1);
    chk_quiet("abort");
    rst = 1'b0;
    step(3);
    chk("abort_no_done", done_tot - b_done, 0);
    snap();
    do_start(3'd4);
    wait_idle("r4");
    chk_counts("r4", 16, 4, 256, 1);

    // start re-asserted during WAIT is ignored.
    snap();
    do_start(3'd2);
    n = 0;
    while (!mul_rst && n < 100) begin
      @(negedge clk);
      n++;
    end
    step(1);
    start = 1'b1;
    rank  = 3'd4;
    step(1);
    start = 1'b0;
    wait_idle("rewait");
    chk_counts("rewait", 4, 2, 128, 1);

    // mul_done held high: first WAIT cycle must be ignored,
    // giving 2*(1 + 2*3 + 64) + 1 = 143 busy cycles.
    force_high = 1'b1;
    snap();
    do_start(3'd2);
    wait_idle("forced");
    chk("forced_busy_cycles", busy_tot - b_busy, 143);
    chk("forced_mul_rst", rst_tot - b_rst, 4);
    force_high = 1'b0;

    // rst and start in the same cycle: rst wins.
    snap();
    rst   = 1'b1;
    start = 1'b1;
    rank  = 3'd3;
    step(1);
    rst   = 1'b0;
    start = 1'b0;
    step(2);
    chk("rst_start_busy", {31'd0, busy}, 32'd0);
    chk("rst_start_clr", clr_tot - b_clr, 0);

`ifdef MATVEC_TRANSPOSE_EN
    snap();
    start     = 1'b1;
    rank      = 3'd3;
    transpose = 1'b1;
    step(1);
    start     = 1'b0;
    transpose = 1'b0;
    wait_idle("tr");
    chk("tr_a_base_0", {22'd0, a_seq[0]}, 32'd0);
    chk("tr_a_base_1", {22'd0, a_seq[1]}, 32'd156);
    chk("tr_a_base_2", {22'd0, a_seq[2]}, 32'd312);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
